instr_fetch: RTL

- Front-end stage directly upstream of instr_decode. Holds the program counter (PC) and a small on-chip instruction memory (IMEM), and owns the IF/ID pipeline register.
- instruction_out drives the decode stage's `instruction` input. pc_out and valid_out travel alongside it.
- Supports stall, flush, and PC redirect from later stages, plus a side write port used to load IMEM.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/instr_mem.sv | 25 ++
 rtl/instr_fetch.sv | 102 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } ifid_t;

  // IF/ID contents for an empty (squashed) slot.
  function automatic ifid_t ifid_bubble();
    ifid_t b;
    b.instr = NOP_INSTR;
    b.pc    = 32'h0000_0000;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: unreset storage, combinational read, synchronous write.
module instr_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem_q [DEPTH];

  // Write port; a same-cycle read sees the old word since the array updates at the edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, IMEM and IF/ID register. Define FETCH_HALT_EN to halt
// after the last IMEM word instead of wrapping the fetch index.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic              redirect_en_in,
  input  logic [31:0]       redirect_pc_in,
  input  logic              imem_wr_en,
  input  logic [ADDR_W-1:0] imem_wr_addr,
  input  logic [31:0]       imem_wr_data,
  output logic [31:0]       instruction_out,
  output logic [31:0]       pc_out,
  output logic              valid_out,
  output logic              halted_out
);

`ifdef FETCH_HALT_EN
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMEM_DEPTH - 1);
`endif

  logic [31:0]  pc_q;
  ifid_t        ifid_q;
  fetch_state_e state_q;
  logic         halted_q;
  logic [31:0]  fetched_s;
  logic [31:0]  redirect_aligned_s;

  assign redirect_aligned_s = redirect_pc_in & 32'hFFFF_FFFC;

  instr_mem #(
    .DEPTH (IMEM_DEPTH),
    .AW    (ADDR_W)
  ) u_imem (
    .clk     (clk),
    .wr_en   (imem_wr_en),
    .wr_addr (imem_wr_addr),
    .wr_data (imem_wr_data),
    .rd_addr (pc_q[ADDR_W+1:2]),
    .rd_data (fetched_s)
  );

  // PC, fetch FSM and IF/ID register; priority redirect > halted > flush > stall > fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      ifid_q   <= ifid_bubble();
      state_q  <= FETCH;
      halted_q <= 1'b0;
    end else if (redirect_en_in) begin
      pc_q     <= redirect_aligned_s;
      ifid_q   <= ifid_bubble();
      state_q  <= FETCH;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        HALTED: begin
          ifid_q   <= ifid_bubble();
          halted_q <= 1'b1;
        end
        FETCH: begin
          if (flush_in) begin
            ifid_q <= ifid_bubble();
          end else if (!stall_in) begin
            ifid_q.instr <= fetched_s;
            ifid_q.pc    <= pc_q;
            ifid_q.valid <= 1'b1;
`ifdef FETCH_HALT_EN
            if (pc_q[ADDR_W+1:2] == LAST_IDX) begin
              state_q  <= HALTED;
              halted_q <= 1'b1;
            end else begin
              pc_q <= pc_q + PC_STEP;
            end
`else
            pc_q <= pc_q + PC_STEP;
`endif
          end else begin
            ifid_q <= ifid_q;
          end
        end
        default: begin
          state_q <= FETCH;
          ifid_q  <= ifid_bubble();
        end
      endcase
    end
  end

  assign instruction_out = ifid_q.instr;
  assign pc_out          = ifid_q.pc;
  assign valid_out       = ifid_q.valid;
  assign halted_out      = halted_q;

endmodule
